// File: rtl/qdr_port_arb.sv
// rtl/qdr_port_arb.sv - two-port round-robin arbiter in front of a QDRII+ MIG user port
// Write and read channels arbitrate independently; a tag FIFO steers read returns.
module qdr_port_arb #(
    parameter int ADDR_WIDTH     = 18,
    parameter int APP_DATA_WIDTH = 144,
    parameter int APP_BW_WIDTH   = 16,
    parameter int TAG_DEPTH      = 32
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic                          init_calib_complete,
    input  logic                          p0_wr_valid,
    output logic                          p0_wr_ready,
    input  logic [ADDR_WIDTH-1:0]         p0_wr_addr,
    input  logic [APP_DATA_WIDTH-1:0]     p0_wr_data,
    input  logic [APP_BW_WIDTH-1:0]       p0_wr_bw_n,
    input  logic                          p0_rd_valid,
    output logic                          p0_rd_ready,
    input  logic [ADDR_WIDTH-1:0]         p0_rd_addr,
    output logic                          p0_rd_data_valid,
    output logic [APP_DATA_WIDTH-1:0]     p0_rd_data,
    input  logic                          p1_wr_valid,
    output logic                          p1_wr_ready,
    input  logic [ADDR_WIDTH-1:0]         p1_wr_addr,
    input  logic [APP_DATA_WIDTH-1:0]     p1_wr_data,
    input  logic [APP_BW_WIDTH-1:0]       p1_wr_bw_n,
    input  logic                          p1_rd_valid,
    output logic                          p1_rd_ready,
    input  logic [ADDR_WIDTH-1:0]         p1_rd_addr,
    output logic                          p1_rd_data_valid,
    output logic [APP_DATA_WIDTH-1:0]     p1_rd_data,
    output logic                          app_wr_cmd0,
    output logic [ADDR_WIDTH-1:0]         app_wr_addr0,
    output logic [APP_DATA_WIDTH-1:0]     app_wr_data0,
    output logic [APP_BW_WIDTH-1:0]       app_wr_bw_n0,
    output logic                          app_rd_cmd0,
    output logic [ADDR_WIDTH-1:0]         app_rd_addr0,
    input  logic                          app_rd_valid0,
    input  logic [APP_DATA_WIDTH-1:0]     app_rd_data0,
    output logic [$clog2(TAG_DEPTH):0]    rd_outstanding,
    output logic                          err_unexp_rd
);

    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Pointer value 0 gives port 0 priority, 1 gives port 1 priority.
    logic                      wr_ptr_q, wr_ptr_d;
    logic                      rd_ptr_q, rd_ptr_d;
    logic                      wr_gnt0, wr_gnt1, rd_gnt0, rd_gnt1;
    logic                      rd_room, push, pop;
    logic                      wr_cmd_q, rd_cmd_q;
    logic [ADDR_WIDTH-1:0]     wr_addr_q, rd_addr_q;
    logic [APP_DATA_WIDTH-1:0] wr_data_q, rd_data_q;
    logic [APP_BW_WIDTH-1:0]   wr_bw_n_q;
    logic [TAG_DEPTH-1:0]      tag_mem_q;
    logic [PTR_W-1:0]          tag_wr_idx_q, tag_rd_idx_q;
    logic [CNT_W-1:0]          rd_cnt_q, rd_cnt_d;
    logic [1:0]                rd_vld_q;
    logic                      err_q;

    always_comb begin
        wr_gnt0  = init_calib_complete & p0_wr_valid & (~p1_wr_valid | ~wr_ptr_q);
        wr_gnt1  = init_calib_complete & p1_wr_valid & (~p0_wr_valid |  wr_ptr_q);
        rd_room  = rd_cnt_q < CNT_W'(TAG_DEPTH);
        rd_gnt0  = init_calib_complete & rd_room & p0_rd_valid & (~p1_rd_valid | ~rd_ptr_q);
        rd_gnt1  = init_calib_complete & rd_room & p1_rd_valid & (~p0_rd_valid |  rd_ptr_q);
        wr_ptr_d = wr_gnt0 ? 1'b1 : (wr_gnt1 ? 1'b0 : wr_ptr_q);
        rd_ptr_d = rd_gnt0 ? 1'b1 : (rd_gnt1 ? 1'b0 : rd_ptr_q);
        push     = rd_gnt0 | rd_gnt1;
        // A return with nothing outstanding is flagged, never popped.
        pop      = app_rd_valid0 & (rd_cnt_q != '0);
        rd_cnt_d = rd_cnt_q;
        if (push && !pop) begin
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end else if (pop && !push) begin
            rd_cnt_d = rd_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            wr_cmd_q     <= 1'b0;
            rd_cmd_q     <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_bw_n_q    <= '1;
            rd_addr_q    <= '0;
            tag_mem_q    <= '0;
            tag_wr_idx_q <= '0;
            tag_rd_idx_q <= '0;
            rd_cnt_q     <= '0;
            rd_vld_q     <= 2'b00;
            rd_data_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_cmd_q <= wr_gnt0 | wr_gnt1;
            rd_cmd_q <= push;
            if (wr_gnt0 || wr_gnt1) begin
                wr_addr_q <= wr_gnt1 ? p1_wr_addr : p0_wr_addr;
                wr_data_q <= wr_gnt1 ? p1_wr_data : p0_wr_data;
                wr_bw_n_q <= wr_gnt1 ? p1_wr_bw_n : p0_wr_bw_n;
            end
            if (push) begin
                rd_addr_q               <= rd_gnt1 ? p1_rd_addr : p0_rd_addr;
                tag_mem_q[tag_wr_idx_q] <= rd_gnt1;
                tag_wr_idx_q            <= tag_wr_idx_q + PTR_W'(1);
            end
            if (pop) begin
                tag_rd_idx_q <= tag_rd_idx_q + PTR_W'(1);
                rd_data_q    <= app_rd_data0;
            end
            rd_vld_q[0] <= pop & ~tag_mem_q[tag_rd_idx_q];
            rd_vld_q[1] <= pop &  tag_mem_q[tag_rd_idx_q];
            rd_cnt_q    <= rd_cnt_d;
            if (app_rd_valid0 && !pop) begin
                err_q <= 1'b1;
            end
        end
    end

    assign p0_wr_ready      = wr_gnt0;
    assign p1_wr_ready      = wr_gnt1;
    assign p0_rd_ready      = rd_gnt0;
    assign p1_rd_ready      = rd_gnt1;
    assign app_wr_cmd0      = wr_cmd_q;
    assign app_wr_addr0     = wr_addr_q;
    assign app_wr_data0     = wr_data_q;
    assign app_wr_bw_n0     = wr_bw_n_q;
    assign app_rd_cmd0      = rd_cmd_q;
    assign app_rd_addr0     = rd_addr_q;
    assign p0_rd_data_valid = rd_vld_q[0];
    assign p1_rd_data_valid = rd_vld_q[1];
    assign p0_rd_data       = rd_data_q;
    assign p1_rd_data       = rd_data_q;
    assign rd_outstanding   = rd_cnt_q;
    assign err_unexp_rd     = err_q;

endmodule

// File: tb/tb_qdr_port_arb.sv
// tb/tb_qdr_port_arb.sv - directed vector bench for qdr_port_arb
module tb_qdr_port_arb;

    logic         sys_clk = 1'b0;
    logic         sys_rst;
    logic         init_calib_complete;
    logic         p0_wr_valid, p0_wr_ready, p0_rd_valid, p0_rd_ready, p0_rd_data_valid;
    logic         p1_wr_valid, p1_wr_ready, p1_rd_valid, p1_rd_ready, p1_rd_data_valid;
    logic [17:0]  p0_wr_addr, p0_rd_addr, p1_wr_addr, p1_rd_addr;
    logic [143:0] p0_wr_data, p1_wr_data, p0_rd_data, p1_rd_data;
    logic [15:0]  p0_wr_bw_n, p1_wr_bw_n;
    logic         app_wr_cmd0, app_rd_cmd0, app_rd_valid0;
    logic [17:0]  app_wr_addr0, app_rd_addr0;
    logic [143:0] app_wr_data0, app_rd_data0;
    logic [15:0]  app_wr_bw_n0;
    logic [5:0]   rd_outstanding;
    logic         err_unexp_rd;

    int vectors = 0;
    int miscompares = 0;

    always #5 sys_clk = ~sys_clk;

    qdr_port_arb dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .init_calib_complete(init_calib_complete),
        .p0_wr_valid(p0_wr_valid), .p0_wr_ready(p0_wr_ready), .p0_wr_addr(p0_wr_addr),
        .p0_wr_data(p0_wr_data), .p0_wr_bw_n(p0_wr_bw_n),
        .p0_rd_valid(p0_rd_valid), .p0_rd_ready(p0_rd_ready), .p0_rd_addr(p0_rd_addr),
        .p0_rd_data_valid(p0_rd_data_valid), .p0_rd_data(p0_rd_data),
        .p1_wr_valid(p1_wr_valid), .p1_wr_ready(p1_wr_ready), .p1_wr_addr(p1_wr_addr),
        .p1_wr_data(p1_wr_data), .p1_wr_bw_n(p1_wr_bw_n),
        .p1_rd_valid(p1_rd_valid), .p1_rd_ready(p1_rd_ready), .p1_rd_addr(p1_rd_addr),
        .p1_rd_data_valid(p1_rd_data_valid), .p1_rd_data(p1_rd_data),
        .app_wr_cmd0(app_wr_cmd0), .app_wr_addr0(app_wr_addr0), .app_wr_data0(app_wr_data0),
        .app_wr_bw_n0(app_wr_bw_n0), .app_rd_cmd0(app_rd_cmd0), .app_rd_addr0(app_rd_addr0),
        .app_rd_valid0(app_rd_valid0), .app_rd_data0(app_rd_data0),
        .rd_outstanding(rd_outstanding), .err_unexp_rd(err_unexp_rd)
    );

    typedef struct {
        logic        calib, v0, v1;
        logic [17:0] a0, a1;
        logic        r0, r1, cmd;
        logic [17:0] addr;
    } wr_vec_t;

    wr_vec_t wv[14];

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    initial begin
        // calib, v0, v1, a0, a1, ready0, ready1, cmd at T+1, addr at T+1
        wv[0]  = '{1'b0, 1'b1, 1'b0, 18'h100, 18'h000, 1'b0, 1'b0, 1'b0, 18'h000};
        wv[1]  = '{1'b0, 1'b1, 1'b0, 18'h100, 18'h000, 1'b0, 1'b0, 1'b0, 18'h000};
        wv[2]  = '{1'b0, 1'b1, 1'b0, 18'h100, 18'h000, 1'b0, 1'b0, 1'b0, 18'h000};
        wv[3]  = '{1'b1, 1'b1, 1'b0, 18'h100, 18'h000, 1'b1, 1'b0, 1'b1, 18'h100};
        wv[4]  = '{1'b1, 1'b1, 1'b1, 18'h101, 18'h201, 1'b0, 1'b1, 1'b1, 18'h201};
        wv[5]  = '{1'b1, 1'b1, 1'b1, 18'h101, 18'h202, 1'b1, 1'b0, 1'b1, 18'h101};
        wv[6]  = '{1'b1, 1'b1, 1'b1, 18'h102, 18'h202, 1'b0, 1'b1, 1'b1, 18'h202};
        wv[7]  = '{1'b1, 1'b1, 1'b1, 18'h102, 18'h203, 1'b1, 1'b0, 1'b1, 18'h102};
        wv[8]  = '{1'b1, 1'b1, 1'b1, 18'h103, 18'h203, 1'b0, 1'b1, 1'b1, 18'h203};
        wv[9]  = '{1'b1, 1'b0, 1'b0, 18'h103, 18'h203, 1'b0, 1'b0, 1'b0, 18'h203};
        wv[10] = '{1'b1, 1'b0, 1'b1, 18'h103, 18'h204, 1'b0, 1'b1, 1'b1, 18'h204};
        wv[11] = '{1'b0, 1'b1, 1'b1, 18'h103, 18'h205, 1'b0, 1'b0, 1'b0, 18'h204};
        wv[12] = '{1'b1, 1'b1, 1'b1, 18'h103, 18'h205, 1'b1, 1'b0, 1'b1, 18'h103};
        wv[13] = '{1'b1, 1'b0, 1'b1, 18'h104, 18'h205, 1'b0, 1'b1, 1'b1, 18'h205};

        sys_rst = 1'b0; init_calib_complete = 1'b0;
        p0_wr_valid = 0; p1_wr_valid = 0; p0_rd_valid = 0; p1_rd_valid = 0;
        p0_wr_addr = '0; p1_wr_addr = '0; p0_rd_addr = '0; p1_rd_addr = '0;
        p0_wr_data = '0; p1_wr_data = '0; p0_wr_bw_n = 16'h1111; p1_wr_bw_n = 16'h2222;
        app_rd_valid0 = 0; app_rd_data0 = '0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_wr_cmd", app_wr_cmd0, 0);
        chk("rst_rd_cmd", app_rd_cmd0, 0);
        chk("rst_bw_n", app_wr_bw_n0, 16'hFFFF);
        chk("rst_wr_addr", app_wr_addr0, 0);
        chk("rst_outstanding", rd_outstanding, 0);
        chk("rst_err", err_unexp_rd, 0);
        chk("rst_rd_dv", {p0_rd_data_valid, p1_rd_data_valid}, 0);
        @(negedge sys_clk) sys_rst = 1'b1;

        // Write arbitration table
        for (int i = 0; i < 14; i++) begin
            @(negedge sys_clk);
            init_calib_complete = wv[i].calib;
            p0_wr_valid = wv[i].v0; p1_wr_valid = wv[i].v1;
            p0_wr_addr = wv[i].a0;  p1_wr_addr = wv[i].a1;
            p0_wr_data = {8{wv[i].a0}}; p1_wr_data = {8{wv[i].a1}};
            #1;
            chk($sformatf("wr_ready[%0d]", i), {p0_wr_ready, p1_wr_ready}, {wv[i].r0, wv[i].r1});
            @(posedge sys_clk);
            #1;
            chk($sformatf("wr_cmd[%0d]", i), app_wr_cmd0, wv[i].cmd);
            chk($sformatf("wr_addr[%0d]", i), app_wr_addr0, wv[i].addr);
            if (wv[i].cmd) begin
                chk($sformatf("wr_data[%0d]", i), app_wr_data0, {8{wv[i].addr}});
                chk($sformatf("wr_bw[%0d]", i), app_wr_bw_n0, wv[i].addr[9] ? 16'h2222 : 16'h1111);
            end
        end
        @(negedge sys_clk);
        p0_wr_valid = 0; p1_wr_valid = 0;

        // In-order read return routing
        init_calib_complete = 0; p1_rd_valid = 1; p1_rd_addr = 18'h00010;
        #1 chk("rd_nocal_ready", p1_rd_ready, 0);
        @(posedge sys_clk); #1 chk("rd_nocal_cmd", app_rd_cmd0, 0);
        @(negedge sys_clk); init_calib_complete = 1;
        #1 chk("rd_a_ready", {p0_rd_ready, p1_rd_ready}, 2'b01);
        @(posedge sys_clk); #1 chk("rd_a_addr", {app_rd_cmd0, app_rd_addr0}, {1'b1, 18'h00010});
        @(negedge sys_clk); p1_rd_valid = 0; p0_rd_valid = 1; p0_rd_addr = 18'h00020;
        #1 chk("rd_b_ready", {p0_rd_ready, p1_rd_ready}, 2'b10);
        @(posedge sys_clk); #1 chk("rd_b_addr", {app_rd_cmd0, app_rd_addr0}, {1'b1, 18'h00020});
        @(negedge sys_clk); p0_rd_valid = 0; p1_rd_valid = 1; p1_rd_addr = 18'h00030;
        #1 chk("rd_c_ready", {p0_rd_ready, p1_rd_ready}, 2'b01);
        @(posedge sys_clk); #1 chk("rd_c_addr", {app_rd_cmd0, app_rd_addr0}, {1'b1, 18'h00030});
        chk("rd_out3", rd_outstanding, 3);
        @(negedge sys_clk); p1_rd_valid = 0; app_rd_valid0 = 1; app_rd_data0 = 144'hA;
        @(posedge sys_clk); #1;
        chk("ret_a_dv", {p0_rd_data_valid, p1_rd_data_valid}, 2'b01);
        chk("ret_a_data", p1_rd_data, 144'hA);
        chk("ret_a_out", rd_outstanding, 2);
        @(negedge sys_clk); app_rd_data0 = 144'hB;
        @(posedge sys_clk); #1;
        chk("ret_b_dv", {p0_rd_data_valid, p1_rd_data_valid}, 2'b10);
        chk("ret_b_data", p0_rd_data, 144'hB);
        chk("ret_b_out", rd_outstanding, 1);
        @(negedge sys_clk); app_rd_data0 = 144'hC;
        @(posedge sys_clk); #1;
        chk("ret_c_dv", {p0_rd_data_valid, p1_rd_data_valid}, 2'b01);
        chk("ret_c_data", p1_rd_data, 144'hC);
        chk("ret_c_out", rd_outstanding, 0);
        chk("err_before", err_unexp_rd, 0);

        // Unexpected return with empty tag FIFO
        @(posedge sys_clk); #1;
        chk("unexp_dv", {p0_rd_data_valid, p1_rd_data_valid}, 2'b00);
        chk("unexp_err", err_unexp_rd, 1);
        chk("unexp_out", rd_outstanding, 0);
        @(negedge sys_clk); app_rd_valid0 = 0;
        repeat (3) @(posedge sys_clk);
        #1 chk("err_sticky", err_unexp_rd, 1);

        // Fill the tag FIFO, then return one while requesting
        for (int i = 0; i < 32; i++) begin
            @(negedge sys_clk); p0_rd_valid = 1; p0_rd_addr = 18'(i);
            #1 chk($sformatf("fill_ready[%0d]", i), p0_rd_ready, 1);
        end
        @(negedge sys_clk); #1;
        chk("full_ready", p0_rd_ready, 0);
        chk("full_out", rd_outstanding, 32);
        app_rd_valid0 = 1; app_rd_data0 = 144'h55;
        @(posedge sys_clk); #1;
        chk("full_pop_out", rd_outstanding, 31);
        chk("full_pop_dv", {p0_rd_data_valid, p1_rd_data_valid}, 2'b10);
        @(negedge sys_clk); #1 chk("after_pop_ready", p0_rd_ready, 1);
        @(posedge sys_clk); #1 chk("pushpop_out", rd_outstanding, 31);
        @(negedge sys_clk); app_rd_valid0 = 0; p0_rd_valid = 0;
        @(posedge sys_clk); #1 chk("idle_out", rd_outstanding, 31);

        // Asynchronous reset mid-operation
        @(posedge sys_clk); #3 sys_rst = 0;
        #1;
        chk("arst_out", rd_outstanding, 0);
        chk("arst_err", err_unexp_rd, 0);
        chk("arst_bw", app_wr_bw_n0, 16'hFFFF);
        chk("arst_cmd", {app_wr_cmd0, app_rd_cmd0}, 2'b00);
        @(negedge sys_clk) sys_rst = 1;
        @(negedge sys_clk) app_rd_valid0 = 1;
        @(posedge sys_clk); #1;
        chk("late_ret_err", err_unexp_rd, 1);
        chk("late_ret_dv", {p0_rd_data_valid, p1_rd_data_valid}, 2'b00);
        @(negedge sys_clk) app_rd_valid0 = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
